// File: rtl/lc3b_types.sv
// ============================================================================
// Module      : lc3b_types
// Description : Shared store-queue types, entry layout and depth constant.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lc3b_types;

    localparam int SQ_DEPTH = 8;

    typedef logic [3:0] lc3b_sq_id;
    typedef logic [1:0] lc3b_mem_wmask;

    typedef enum logic [1:0] {
        sq_str = 2'd0,
        sq_stb = 2'd1,
        sq_sti = 2'd2
    } lc3b_lsq_op;

    typedef struct packed {
        logic        valid;
        lc3b_lsq_op  op;
        logic [3:0]  rob_id;
        logic        addr_ready;
        logic [15:0] address;
        logic        val_ready;
        logic [15:0] value;
        logic [3:0]  val_rob_id;
    } lc3b_sq_entry;

    // Slot index of a queue id; the top bit is the wrap marker.
    function automatic logic [2:0] sq_index(lc3b_sq_id id);
        return id[2:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/store_queue_if.sv
// ============================================================================
// Module      : store_queue_if
// Description : Dispatch/AGU/CDB/commit/memory signal bundle of the store queue.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface store_queue_if;
    import lc3b_types::*;

    logic          alloc_valid;
    lc3b_lsq_op    alloc_op;
    logic [3:0]    alloc_rob_id;
    logic          alloc_val_ready;
    logic [15:0]   alloc_value;
    logic [3:0]    alloc_val_rob_id;
    logic          alloc_ready;
    lc3b_sq_id     alloc_sq_id;
    logic          agu_valid;
    lc3b_sq_id     agu_sq_id;
    logic [15:0]   agu_address;
    logic          cdb_ready;
    logic [3:0]    cdb_dest;
    logic [15:0]   cdb_value;
    logic          commit_valid;
    logic [3:0]    commit_rob_id;
    logic          flush;
    logic          mem_req;
    logic [15:0]   mem_addr;
    logic [15:0]   mem_wdata;
    lc3b_mem_wmask mem_wmask;
    logic          mem_resp;
    logic          full;
    logic          empty;

    modport master (
        output alloc_valid, alloc_op, alloc_rob_id, alloc_val_ready, alloc_value,
               alloc_val_rob_id, agu_valid, agu_sq_id, agu_address, cdb_ready,
               cdb_dest, cdb_value, commit_valid, commit_rob_id, flush, mem_resp,
        input  alloc_ready, alloc_sq_id, mem_req, mem_addr, mem_wdata, mem_wmask,
               full, empty
    );

    modport slave (
        input  alloc_valid, alloc_op, alloc_rob_id, alloc_val_ready, alloc_value,
               alloc_val_rob_id, agu_valid, agu_sq_id, agu_address, cdb_ready,
               cdb_dest, cdb_value, commit_valid, commit_rob_id, flush, mem_resp,
        output alloc_ready, alloc_sq_id, mem_req, mem_addr, mem_wdata, mem_wmask,
               full, empty
    );

endinterface

`default_nettype wire

// File: rtl/sq_mem_ctrl.sv
// ============================================================================
// Module      : sq_mem_ctrl
// Description : Head-of-queue memory write FSM with byte-lane steering.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sq_mem_ctrl
    import lc3b_types::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  lc3b_sq_entry  head_entry,
    input  logic          head_committed,
    input  logic          mem_resp,
    output logic          mem_req,
    output logic [15:0]   mem_addr,
    output logic [15:0]   mem_wdata,
    output lc3b_mem_wmask mem_wmask,
    output logic          retire
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] WRITE = 1'b1;

    logic [0:0]    state;
    logic          start;
    logic [15:0]   steer_data;
    lc3b_mem_wmask steer_mask;

    assign start = (state == IDLE) && head_entry.valid && head_committed &&
                   head_entry.addr_ready && head_entry.val_ready;

    // Indirect stores arrive with their final address, so they write like sq_str.
    always_comb begin
        steer_data = head_entry.value;
        steer_mask = 2'b11;
        if (head_entry.op == sq_stb) begin
            steer_data = {head_entry.value[7:0], head_entry.value[7:0]};
            steer_mask = head_entry.address[0] ? 2'b10 : 2'b01;
        end
    end

    // Request fields are latched so later AGU/CDB traffic cannot disturb them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wmask <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= WRITE;
                        mem_addr  <= head_entry.address;
                        mem_wdata <= steer_data;
                        mem_wmask <= steer_mask;
                    end
                end
                WRITE: begin
                    if (mem_resp) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign mem_req = (state == WRITE);
    assign retire  = (state == WRITE) && mem_resp;

endmodule

`default_nettype wire

// File: rtl/store_queue.sv
// ============================================================================
// Module      : store_queue
// Description : 8-entry circular store queue with AGU/CDB snooping and commit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module store_queue
    import lc3b_types::*;
(
    input  logic         clk,
    input  logic         rst_n,
    store_queue_if.slave sq
);

    lc3b_sq_entry        entries [SQ_DEPTH];
    logic [SQ_DEPTH-1:0] committed;
    logic [SQ_DEPTH-1:0] wrap_bits;
    lc3b_sq_id           head;
    lc3b_sq_id           tail;
    logic [SQ_DEPTH-1:0] agu_hit;
    logic [SQ_DEPTH-1:0] cdb_hit;
    logic                full;
    logic                alloc_ready;
    logic                retire;
    logic                alloc_fire;
    logic                alloc_cdb_hit;
    logic                commit_hit;
    logic [2:0]          commit_idx;
    logic [3:0]          commit_cnt;
    lc3b_sq_entry        new_entry;
    lc3b_sq_entry        head_entry;

    assign full        = (sq_index(head) == sq_index(tail)) && (head[3] != tail[3]);
    // A retiring head frees a slot in the same cycle, so a full queue still accepts.
    assign alloc_ready = !full || retire;
    assign alloc_fire  = sq.alloc_valid && alloc_ready && !sq.flush;

    assign sq.full        = full;
    assign sq.empty       = (head == tail);
    assign sq.alloc_ready = alloc_ready;
    assign sq.alloc_sq_id = tail;

    generate
        for (genvar i = 0; i < SQ_DEPTH; i++) begin : g_snoop
            assign agu_hit[i] = sq.agu_valid && entries[i].valid &&
                                (sq.agu_sq_id == {wrap_bits[i], 3'(i)});
            assign cdb_hit[i] = sq.cdb_ready && entries[i].valid && !entries[i].val_ready &&
                                (sq.cdb_dest == entries[i].val_rob_id);
        end
    endgenerate

    assign alloc_cdb_hit = sq.cdb_ready && (sq.cdb_dest == sq.alloc_val_rob_id);

    always_comb begin
        new_entry            = '0;
        new_entry.valid      = 1'b1;
        new_entry.op         = sq.alloc_op;
        new_entry.rob_id     = sq.alloc_rob_id;
        new_entry.val_rob_id = sq.alloc_val_rob_id;
        new_entry.val_ready  = sq.alloc_val_ready || alloc_cdb_hit;
        new_entry.value      = (!sq.alloc_val_ready && alloc_cdb_hit) ? sq.cdb_value
                                                                      : sq.alloc_value;
    end

    // Age-ordered scan from head picks the oldest matching uncommitted store.
    always_comb begin
        commit_hit = 1'b0;
        commit_idx = '0;
        commit_cnt = '0;
        for (int k = 0; k < SQ_DEPTH; k++) begin
            if (!commit_hit && sq.commit_valid &&
                entries[sq_index(head) + 3'(k)].valid &&
                !committed[sq_index(head) + 3'(k)] &&
                (entries[sq_index(head) + 3'(k)].rob_id == sq.commit_rob_id)) begin
                commit_hit = 1'b1;
                commit_idx = sq_index(head) + 3'(k);
            end
            commit_cnt = commit_cnt + 4'(entries[k].valid && committed[k]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SQ_DEPTH; i++) begin
                entries[i] <= '0;
            end
            committed <= '0;
            wrap_bits <= '0;
            head      <= '0;
            tail      <= '0;
        end else begin
            for (int i = 0; i < SQ_DEPTH; i++) begin
                if (agu_hit[i]) begin
                    entries[i].address    <= sq.agu_address;
                    entries[i].addr_ready <= 1'b1;
                end
                if (cdb_hit[i]) begin
                    entries[i].value     <= sq.cdb_value;
                    entries[i].val_ready <= 1'b1;
                end
                if (sq.flush && !committed[i]) begin
                    entries[i].valid <= 1'b0;
                end
            end
            if (commit_hit && !sq.flush) begin
                committed[commit_idx] <= 1'b1;
            end
            if (retire) begin
                entries[sq_index(head)].valid <= 1'b0;
                committed[sq_index(head)]     <= 1'b0;
                head                          <= head + 4'd1;
            end
            // When full, tail and head share a slot; the new entry overrides the retire.
            if (alloc_fire) begin
                entries[sq_index(tail)]   <= new_entry;
                committed[sq_index(tail)] <= 1'b0;
                wrap_bits[sq_index(tail)] <= tail[3];
                tail                      <= tail + 4'd1;
            end
            if (sq.flush) begin
                tail <= head + commit_cnt;
            end
        end
    end

    assign head_entry = entries[sq_index(head)];

    sq_mem_ctrl u_mem_ctrl (
        .clk            (clk),
        .rst_n          (rst_n),
        .head_entry     (head_entry),
        .head_committed (committed[sq_index(head)]),
        .mem_resp       (sq.mem_resp),
        .mem_req        (sq.mem_req),
        .mem_addr       (sq.mem_addr),
        .mem_wdata      (sq.mem_wdata),
        .mem_wmask      (sq.mem_wmask),
        .retire         (retire)
    );

endmodule

`default_nettype wire
